seven_segment_capture: RTL and testbench

- Receive-side counterpart of the hex-to-7-segment driver: watches a multiplexed, active-low 7-segment bus (segments plus digit selects) and reconstructs the hex nibble shown on each digit.
- Used in self-check/loopback builds: the display driver's pins are fed back into this block, so firmware or a bench can read back what is actually on the display.
- Filters ghosting and multiplex transitions with a stability counter before committing a digit.

---
 rtl/seven_seg_pkg.sv | 53 +++++
 rtl/seven_segment_glyph_decode.sv | 20 ++
 rtl/seven_segment_capture.sv | 167 ++++++++++++++++
 tb/tb_seven_segment_capture.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: glyph table (active-high ABCDEFG), blank bus
// value, pattern/nibble conversion helpers and the capture FSM state type.
package seven_seg_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} cap_state_e;

  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1110011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

  // Bus value with every active-low segment released.
  localparam logic [6:0] BLANK_PATTERN = 7'h7F;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
    GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F
  };

  typedef struct packed {
    logic       legal;
    logic [3:0] nibble;
  } glyph_match_t;

  function automatic logic [6:0] nibble_to_pattern(input logic [3:0] nibble);
    return ~GLYPH_TABLE[nibble];
  endfunction

  function automatic glyph_match_t pattern_to_nibble(input logic [6:0] pattern);
    glyph_match_t m;
    m = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (~pattern == GLYPH_TABLE[i]) begin
        m.legal  = 1'b1;
        m.nibble = 4'(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/seven_segment_glyph_decode.sv
// Combinational active-low segment pattern to {legal, blank, nibble} decoder.
module seven_segment_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  glyph_match_t match;

  always_comb begin
    match  = pattern_to_nibble(pattern);
    legal  = match.legal;
    nibble = match.nibble;
    blank  = (pattern == BLANK_PATTERN);
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Reconstructs per-digit hex values from a multiplexed active-low 7-segment bus.
// Define SEG_CAPTURE_SYNC_EN to add a 2-flop input synchronizer (asynchronous loopback).
module seven_segment_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                    CLK_IN,
  input  logic                    RST_N_IN,
  input  logic [6:0]              SEG_IN,
  input  logic [NUM_DIGITS-1:0]   DIGIT_SEL_N_IN,
  output logic [4*NUM_DIGITS-1:0] VALUE_OUT,
  output logic [NUM_DIGITS-1:0]   VALID_OUT,
  output logic [NUM_DIGITS-1:0]   BLANK_OUT,
  output logic                    UPDATE_OUT,
  output logic                    ERROR_OUT
);

  logic [6:0]            seg_src;
  logic [NUM_DIGITS-1:0] sel_src;

`ifdef SEG_CAPTURE_SYNC_EN
  logic [6:0]            seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] sel_s1, sel_s2;

  always_ff @(posedge CLK_IN) begin
    if (!RST_N_IN) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      sel_s1 <= '1;
      sel_s2 <= '1;
    end else begin
      seg_s1 <= SEG_IN;
      seg_s2 <= seg_s1;
      sel_s1 <= DIGIT_SEL_N_IN;
      sel_s2 <= sel_s1;
    end
  end

  assign seg_src = seg_s2;
  assign sel_src = sel_s2;
`else
  assign seg_src = SEG_IN;
  assign sel_src = DIGIT_SEL_N_IN;
`endif

  logic [6:0]            seg_q, seg_p;
  logic [NUM_DIGITS-1:0] sel_q, sel_p;

  always_ff @(posedge CLK_IN) begin
    if (!RST_N_IN) begin
      seg_q <= '1;
      seg_p <= '1;
      sel_q <= '1;
      sel_p <= '1;
    end else begin
      seg_q <= seg_src;
      seg_p <= seg_q;
      sel_q <= sel_src;
      sel_p <= sel_q;
    end
  end

  logic sel_onehot;
  logic changed;

  always_comb begin
    int unsigned lows;
    lows = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!sel_q[i]) lows++;
    end
    sel_onehot = (lows == 1);
    changed    = (seg_q != seg_p) || (sel_q != sel_p);
  end

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eval;

  always_ff @(posedge CLK_IN) begin
    if (!RST_N_IN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts samples matching the previous one; evaluation fires once per
  // stable run because HOLD never evaluates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eval    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel_onehot) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(1);
        end
      end
      SETTLE, HOLD: begin
        if (changed) begin
          if (sel_onehot) begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (state_q == SETTLE) begin
          if (cnt_q == CNT_W'(STABLE_CYCLES)) begin
            eval    = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic       pat_legal;
  logic       pat_blank;
  logic [3:0] pat_nibble;

  seven_segment_glyph_decode u_decode (
    .pattern (seg_q),
    .legal   (pat_legal),
    .blank   (pat_blank),
    .nibble  (pat_nibble)
  );

  always_ff @(posedge CLK_IN) begin
    if (!RST_N_IN) begin
      VALUE_OUT  <= '0;
      VALID_OUT  <= '0;
      BLANK_OUT  <= '0;
      UPDATE_OUT <= 1'b0;
      ERROR_OUT  <= 1'b0;
    end else begin
      UPDATE_OUT <= eval && (pat_legal || pat_blank);
      ERROR_OUT  <= eval && !pat_legal && !pat_blank;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (eval && !sel_q[i]) begin
          if (pat_legal) begin
            VALUE_OUT[4*i +: 4] <= pat_nibble;
            VALID_OUT[i]        <= 1'b1;
            BLANK_OUT[i]        <= 1'b0;
          end else if (pat_blank) begin
            BLANK_OUT[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Randomized and directed bench for seven_segment_capture against a run-length reference model.
module tb_seven_segment_capture;

  localparam int ND     = 4;
  localparam int STABLE = 4;
`ifdef SEG_CAPTURE_SYNC_EN
  localparam int LAT = STABLE + 3;
`else
  localparam int LAT = STABLE + 1;
`endif

  localparam logic [6:0] GLY [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      seg;
  logic [ND-1:0]   sel;
  logic [4*ND-1:0] value;
  logic [ND-1:0]   valid, blank;
  logic            update, error;

  always #5 clk = ~clk;

  seven_segment_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (STABLE),
    .CNT_W         (8)
  ) dut (
    .CLK_IN         (clk),
    .RST_N_IN       (rst_n),
    .SEG_IN         (seg),
    .DIGIT_SEL_N_IN (sel),
    .VALUE_OUT      (value),
    .VALID_OUT      (valid),
    .BLANK_OUT      (blank),
    .UPDATE_OUT     (update),
    .ERROR_OUT      (error)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pattern commits once it has been sampled LAT-STABLE... i.e.
  // STABLE+1 consecutive identical samples on a single selected digit.
  logic [4*ND-1:0] exp_val;
  logic [ND-1:0]   exp_valid, exp_blank;
  logic            exp_upd, exp_err;
  logic [10:0]     m_prev, m_s1, m_s2;
  int              m_run, m_pend, m_pdig;
  logic [3:0]      m_pnib;

  function automatic int low_count(input logic [ND-1:0] s);
    int n = 0;
    for (int i = 0; i < ND; i++) if (!s[i]) n++;
    return n;
  endfunction

  task automatic model_edge(input logic r, input logic [6:0] sg, input logic [ND-1:0] sl);
    logic [10:0] v;
    if (!r) begin
      exp_val = '0; exp_valid = '0; exp_blank = '0; exp_upd = 0; exp_err = 0;
      m_prev = '1; m_s1 = '1; m_s2 = '1; m_run = 0; m_pend = 0;
    end else begin
      exp_upd = (m_pend == 1 || m_pend == 2);
      exp_err = (m_pend == 3);
      if (m_pend == 1) begin
        exp_val[4*m_pdig +: 4] = m_pnib;
        exp_valid[m_pdig] = 1'b1;
        exp_blank[m_pdig] = 1'b0;
      end else if (m_pend == 2) begin
        exp_blank[m_pdig] = 1'b1;
      end
`ifdef SEG_CAPTURE_SYNC_EN
      v = m_s2; m_s2 = m_s1; m_s1 = {sl, sg};
`else
      v = {sl, sg};
`endif
      m_run  = (v == m_prev) ? m_run + 1 : 1;
      m_prev = v;
      m_pend = 0;
      if (m_run == STABLE + 1 && low_count(v[10:7]) == 1) begin
        for (int i = 0; i < ND; i++) if (!v[7+i]) m_pdig = i;
        if (v[6:0] == 7'h7F) m_pend = 2;
        else begin
          m_pend = 3;
          for (int n = 0; n < 16; n++)
            if (~v[6:0] == GLY[n]) begin m_pend = 1; m_pnib = 4'(n); end
        end
      end
    end
  endtask

  int upd_cnt, err_cnt, step_no, first_upd;

  task automatic step(input logic r, input logic [6:0] sg, input logic [ND-1:0] sl);
    rst_n = r; seg = sg; sel = sl;
    @(posedge clk);
    model_edge(r, sg, sl);
    #1;
    step_no++;
    if (update) begin
      upd_cnt++;
      if (first_upd < 0) first_upd = step_no;
    end
    if (error) err_cnt++;
    check("value",  32'(value),  32'(exp_val));
    check("valid",  32'(valid),  32'(exp_valid));
    check("blank",  32'(blank),  32'(exp_blank));
    check("update", 32'(update), 32'(exp_upd));
    check("error",  32'(error),  32'(exp_err));
  endtask

  task automatic hold(input int n, input logic [6:0] sg, input logic [ND-1:0] sl);
    for (int k = 0; k < n; k++) step(1'b1, sg, sl);
  endtask

  task automatic clear_counts();
    upd_cnt = 0; err_cnt = 0; step_no = 0; first_upd = -1;
  endtask

  initial begin
    logic [6:0]    rs;
    logic [ND-1:0] rsl;
    int            r;

    clear_counts();
    for (int k = 0; k < 3; k++) step(1'b0, 7'h7F, '1);
    clear_counts();
    hold(100, 7'h7F, 4'hF);
    check("idle_upd", 32'(upd_cnt + err_cnt), 0);
    check("idle_valid", 32'(valid), 0);

    clear_counts();
    hold(12, ~GLY[3], 4'hE);
    check("latency", 32'(first_upd), 32'(1 + LAT));
    check("d0_is_3", 32'(value[3:0]), 3);
    check("d0_valid", 32'(valid), 32'h1);
    check("one_update", 32'(upd_cnt), 1);

    clear_counts();
    for (int d = 0; d < ND; d++) hold(10, ~GLY[10 + d], ~(4'b1 << d));
    check("scan_value", 32'(value), 32'hDCBA);
    check("scan_valid", 32'(valid), 32'hF);
    check("scan_updates", 32'(upd_cnt), 4);

    clear_counts();
    for (int t = 0; t < 8; t++) hold(3, (t % 2) ? ~GLY[1] : ~GLY[7], 4'hD);
    check("toggle_nocommit", 32'(upd_cnt + err_cnt), 0);
    hold(10, ~GLY[15], 4'hD);
    check("d1_is_F", 32'(value[7:4]), 32'hF);

    clear_counts();
    hold(12, ~7'b1010101, 4'hB);
    check("illegal_err", 32'(err_cnt), 1);
    check("illegal_upd", 32'(upd_cnt), 0);
    check("illegal_value", 32'(value), 32'hDCFA);
    clear_counts();
    hold(12, ~GLY[8], 4'h3);
    check("twohot_quiet", 32'(upd_cnt + err_cnt), 0);

    clear_counts();
    hold(10, ~GLY[5], 4'hE);
    hold(10, 7'h7F, 4'hE);
    check("blank_d0", 32'(blank[0]), 1);
    check("blank_keeps5", 32'(value[3:0]), 5);
    check("blank_updates", 32'(upd_cnt), 2);

    hold(3, ~GLY[7], 4'hE);
    step(1'b0, ~GLY[7], 4'hE);
    check("rst_value", 32'(value), 0);
    check("rst_flags", 32'({valid, blank, update, error}), 0);

    for (int b = 0; b < 260; b++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        step(1'b0, 7'(($urandom)), 4'($urandom));
        continue;
      end
      rsl = ($urandom_range(0, 9) < 8) ? ~(4'b1 << $urandom_range(0, ND - 1)) : 4'($urandom);
      r = $urandom_range(0, 99);
      if (r < 60)      rs = ~GLY[$urandom_range(0, 15)];
      else if (r < 75) rs = 7'h7F;
      else             rs = 7'($urandom);
      hold($urandom_range(1, 10), rs, rsl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
